// File: rtl/vram_fill_pkg.sv
// Shared video package: framebuffer geometry, fill register map, fill FSM encoding
// and the constant-coefficient row-start helper.
package vram_fill_pkg;

    localparam int unsigned H_RES_DEF   = 640;
    localparam int unsigned V_RES_DEF   = 480;
    localparam logic [7:0]  IO_BASE_DEF = 8'h20;

    localparam int unsigned IOAD_W = 8;
    localparam int unsigned IOWD_W = 16;
    localparam int unsigned ADDR_W = 24;
    localparam int unsigned PIX_W  = 8;
    localparam int unsigned X_W    = 10;
    localparam int unsigned Y_W    = 9;
    localparam int unsigned REG_N  = 6;

    localparam logic [2:0] REG_X0    = 3'd0;
    localparam logic [2:0] REG_Y0    = 3'd1;
    localparam logic [2:0] REG_W     = 3'd2;
    localparam logic [2:0] REG_H     = 3'd3;
    localparam logic [2:0] REG_COLOR = 3'd4;
    localparam logic [2:0] REG_GO    = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_STEP  = 2'd2
    } fill_state_e;

    typedef struct packed {
        logic [X_W-1:0]   x0;
        logic [Y_W-1:0]   y0;
        logic [X_W-1:0]   w;
        logic [Y_W-1:0]   h;
        logic [PIX_W-1:0] color;
    } fill_regs_t;

    // y*hres + x as a shift-add over the set bits of the constant line pitch
    function automatic logic [ADDR_W-1:0] row_start(input logic [X_W-1:0] x,
                                                    input logic [Y_W-1:0] y,
                                                    input int unsigned    hres);
        logic [ADDR_W-1:0] acc;
        acc = ADDR_W'(x);
        for (int i = 0; i < 32; i++) begin
            if (hres[i]) begin
                acc = acc + (ADDR_W'(y) << i);
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/vram_fill_if.sv
// CPU register port plus the pixel write handshake towards the VRAM writer.
interface vram_fill_if;
    import vram_fill_pkg::*;

    logic [IOAD_W-1:0] ioad;
    logic [IOWD_W-1:0] iowdt;
    logic              iow;
    logic [ADDR_W-1:0] wr_addr;
    logic [PIX_W-1:0]  wr_data;
    logic              wr_req;
    logic              wr_ack;
    logic              busy;

    modport master (
        input  ioad, iowdt, iow, wr_ack,
        output wr_addr, wr_data, wr_req, busy
    );

    modport slave (
        output ioad, iowdt, iow, wr_ack,
        input  wr_addr, wr_data, wr_req, busy
    );

endinterface

// File: rtl/vram_fill.sv
// Rectangle fill engine: CPU-programmed clipped rectangle, written pixel by pixel
// in row-major order through a req/ack handshake.
module vram_fill
    import vram_fill_pkg::*;
#(
    parameter int unsigned       H_RES   = H_RES_DEF,
    parameter int unsigned       V_RES   = V_RES_DEF,
    parameter logic [IOAD_W-1:0] IO_BASE = IO_BASE_DEF
) (
    input  logic        clk50,
    input  logic        reset,
    vram_fill_if.master bus
);

    localparam int unsigned       CW       = 16;
    localparam logic [CW-1:0]     H_RES_C  = CW'(H_RES);
    localparam logic [CW-1:0]     V_RES_C  = CW'(V_RES);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_RES);

    fill_regs_t        regs_q;
    fill_state_e       state_q, state_d;
    logic [X_W-1:0]    eff_w_q, col_q;
    logic [Y_W-1:0]    eff_h_q, row_q;
    logic [ADDR_W-1:0] row_base_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [PIX_W-1:0]  wr_data_q;
    logic              wr_req_q;
    logic              busy_q;
    logic              last_q;

    logic [IOAD_W-1:0] off_c;
    logic              reg_hit_c;
    logic              go_c;
    logic              start_c;
    logic              ack_c;
    logic              row_end_c;
    logic              last_px_c;
    logic [CW-1:0]     room_x_c, room_y_c;
    logic [X_W-1:0]    eff_w_c;
    logic [Y_W-1:0]    eff_h_c;
    logic [ADDR_W-1:0] start_addr_c;
    logic              unused_c;

    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign bus.wr_req  = wr_req_q;
    assign bus.busy    = busy_q;

    // Wrapping subtract: addresses below IO_BASE land far above REG_N
    assign off_c     = bus.ioad - IO_BASE;
    assign reg_hit_c = bus.iow && (off_c < IOAD_W'(REG_N));
    assign go_c      = reg_hit_c && (off_c[2:0] == REG_GO);
    assign unused_c  = ^bus.iowdt[IOWD_W-1:X_W];

    // Register block; a running fill works from its own latched copies
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            regs_q <= '0;
        end else if (reg_hit_c) begin
            case (off_c[2:0])
                REG_X0:    regs_q.x0    <= bus.iowdt[X_W-1:0];
                REG_Y0:    regs_q.y0    <= bus.iowdt[Y_W-1:0];
                REG_W:     regs_q.w     <= bus.iowdt[X_W-1:0];
                REG_H:     regs_q.h     <= bus.iowdt[Y_W-1:0];
                REG_COLOR: regs_q.color <= bus.iowdt[PIX_W-1:0];
                default:   ;
            endcase
        end
    end

    // Clip the requested rectangle against the framebuffer edges
    always_comb begin
        room_x_c = H_RES_C - CW'(regs_q.x0);
        room_y_c = V_RES_C - CW'(regs_q.y0);
        eff_w_c  = '0;
        eff_h_c  = '0;
        if (CW'(regs_q.x0) < H_RES_C) begin
            eff_w_c = (CW'(regs_q.w) < room_x_c) ? regs_q.w : X_W'(room_x_c);
        end
        if (CW'(regs_q.y0) < V_RES_C) begin
            eff_h_c = (CW'(regs_q.h) < room_y_c) ? regs_q.h : Y_W'(room_y_c);
        end
    end

    assign start_addr_c = row_start(regs_q.x0, regs_q.y0, H_RES);
    assign start_c      = go_c && !busy_q && (eff_w_c != '0) && (eff_h_c != '0);
    assign ack_c        = (state_q == ST_ISSUE) && bus.wr_ack;
    assign row_end_c    = (col_q == eff_w_q - X_W'(1));
    assign last_px_c    = row_end_c && (row_q == eff_h_q - Y_W'(1));

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // STEP after the final pixel already has busy low, so a GO there starts at once
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_c) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (bus.wr_ack) begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                if (!last_q || start_c) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Walker: row base steps by the line pitch, column by one, no multiply per pixel
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            eff_w_q    <= '0;
            eff_h_q    <= '0;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_req_q   <= 1'b0;
            busy_q     <= 1'b0;
            last_q     <= 1'b0;
        end else if (start_c) begin
            eff_w_q    <= eff_w_c;
            eff_h_q    <= eff_h_c;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= start_addr_c;
            wr_addr_q  <= start_addr_c;
            wr_data_q  <= regs_q.color;
            wr_req_q   <= 1'b1;
            busy_q     <= 1'b1;
            last_q     <= 1'b0;
        end else if (ack_c) begin
            wr_req_q <= 1'b0;
            if (last_px_c) begin
                busy_q <= 1'b0;
                last_q <= 1'b1;
            end else if (row_end_c) begin
                col_q      <= '0;
                row_q      <= row_q + Y_W'(1);
                row_base_q <= row_base_q + ROW_STEP;
                wr_addr_q  <= row_base_q + ROW_STEP;
            end else begin
                col_q     <= col_q + X_W'(1);
                wr_addr_q <= wr_addr_q + ADDR_W'(1);
            end
        end else if ((state_q == ST_STEP) && !last_q) begin
            wr_req_q <= 1'b1;
        end
    end

endmodule
